stim_reset_sequencer: RTL
=========================

# stim_reset_sequencer

Initiator for the stimulus/reset handshake. Accepts stimulus commands from the host side and drives `stimuli_valid`, `do_reset` and `stimuli_data` toward the system reset manager and the DUT. When a command requests a reset, it guarantees a clean low-to-high edge on `stimuli_valid` with `do_reset` high, then tracks the returned `dut_resetn` through assertion, release and a settle window before reporting the stimulus active. Sits between the testbench command port and the reset manager/DUT stimulus inputs.

## Interface
- `PAYLOAD_W`, 32: width of the stimulus payload.
- `SETTLE_CYCLES`, 4: cycles to wait after `dut_resetn` rises before the stimulus is declared active (1..255).
- `RESET_TIMEOUT`, 64: maximum cycles allowed in each reset-wait state (1..65535).
- `clk` in 1: the single clock.
- `reset` in 1: reset is asynchronous and active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_do_reset` in 1: the command requests a DUT reset.
- `cmd_payload` in PAYLOAD_W: stimulus data for the command.
- `stimuli_valid` out 1: level signal, high while a stimulus is applied.
- `do_reset` out 1: reset request, qualified by the rising edge of `stimuli_valid`.
- `stimuli_data` out PAYLOAD_W: registered payload.
- `dut_resetn` in 1: active-low reset returned from the reset manager.
- `active` out 1: stimulus applied and DUT out of reset.
- `err_timeout` out 1: sticky; set when a reset-wait state times out.
- `reset_count` out 16: number of completed DUT resets, saturating at 16'hFFFF.

## Operation
- States: IDLE, ARM, ASSERT, WAIT_LOW, WAIT_HIGH, SETTLE, ACTIVE.
- `cmd_ready` = (IDLE or ACTIVE) && `dut_resetn`. This blocks commands while the boot-time reset is still in effect.
- IDLE/ACTIVE, on accept: latch `cmd_payload` into `stimuli_data` and `cmd_do_reset` internally, then go to ARM.
- ARM (1 cycle): `stimuli_valid`=0 and `do_reset`=0. This guarantees a rising edge, even when the block comes from ACTIVE. Next state is ASSERT.
- ASSERT (1 cycle): `stimuli_valid`=1 and `do_reset`=latched flag. If the flag is 0, go to ACTIVE. If the flag is 1, go to WAIT_LOW.
- WAIT_LOW:
  - Hold `stimuli_valid`=1 and `do_reset`=1.
  - When `dut_resetn`==0, clear `do_reset` and go to WAIT_HIGH.
- WAIT_HIGH:
  - Hold `stimuli_valid`=1 and `do_reset`=0.
  - When `dut_resetn`==1, increment `reset_count` (saturating) and go to SETTLE.
- SETTLE: count SETTLE_CYCLES, then go to ACTIVE.
- ACTIVE: `active`=1 and `stimuli_valid`=1 are held until the next command is accepted.
- Timeout: a counter reloads on entry to WAIT_LOW and on entry to WAIT_HIGH. If it expires before the exit condition, set `err_timeout`, drive `stimuli_valid`=0 and `do_reset`=0, and go to IDLE.
- `dut_resetn` falling while in ACTIVE (unrequested reset): drop `active`, go to WAIT_HIGH, and do not count it in `reset_count`.

## Timing
- Reset values: `cmd_ready`=0 (IDLE is gated by `dut_resetn`), `stimuli_valid`=0, `do_reset`=0, `stimuli_data`=0, `active`=0, `err_timeout`=0, `reset_count`=0, state IDLE.
- Command accepted at cycle N:
  - ARM is visible at N+1.
  - `stimuli_valid` rises at N+2 with `do_reset` valid in the same cycle.
  - Without reset, `active`=1 from N+3.
- With the companion reset manager (16-cycle reset), `dut_resetn` goes low around N+3. `active` asserts SETTLE_CYCLES+1 cycles after `dut_resetn` is sampled high.
- All outputs are registered; there is no combinational path from inputs to outputs except `cmd_ready`, which depends on `dut_resetn`.
- `cmd_valid` arriving in the same cycle as the `dut_resetn` fall in ACTIVE is not accepted, because `cmd_ready`=0.
- Asserting `reset` mid-sequence forces all outputs to their reset values immediately and returns the FSM to IDLE. `err_timeout` and `reset_count` are also cleared.

## Structure
- `stim_seq_pkg`: state enum typedef `stim_seq_state_t` and default constants for `SETTLE_CYCLES` and `RESET_TIMEOUT`.
- The shared down-counter for settle and timeout is a natural sub-module: `sat_down_counter` (load, decrement, zero flag). Everything else stays in a single module.

## Test plan
- Boot: hold `dut_resetn`=0 for 20 cycles after `reset` deasserts -> `cmd_ready` stays 0 and all outputs stay 0; `dut_resetn`=1 -> `cmd_ready`=1.
- Non-reset command, payload 32'hA5A5_0001 -> `stimuli_valid` low at N+1, high at N+2 with `do_reset`=0; `active`=1 at N+3 and `stimuli_data`=32'hA5A5_0001.
- Reset command looped through the real reset manager -> `do_reset` high from N+2 until `dut_resetn` low; `active` exactly SETTLE_CYCLES+1 cycles after `dut_resetn` rises; `reset_count`=1.
- Back-to-back reset commands issued from ACTIVE -> a one-cycle `stimuli_valid` low gap precedes each rise; `reset_count`=2.
- `dut_resetn` held high after a reset request -> `err_timeout`=1 after RESET_TIMEOUT cycles, outputs 0, state IDLE, `reset_count` unchanged.
- Assert `reset` during WAIT_HIGH -> all outputs are 0 in the same cycle, and a subsequent non-reset command behaves as in scenario 2.

Source files
------------

// File: rtl/stim_seq_pkg.sv
// Shared types and defaults for the stimulus/reset handshake initiator.
package stim_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_ASSERT,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_SETTLE,
    ST_ACTIVE
  } stim_seq_state_t;

  localparam int unsigned DEF_SETTLE_CYCLES = 4;
  localparam int unsigned DEF_RESET_TIMEOUT = 64;
  localparam int unsigned CNT_W             = 16;

endpackage

// File: rtl/sat_down_counter.sv
// Loadable down-counter that stops at zero; shared by settle and timeout timing.
module sat_down_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/stim_reset_sequencer.sv
// Stimulus/reset handshake initiator: applies host commands, optionally requests
// a DUT reset, and tracks dut_resetn through assertion, release and settle.
module stim_reset_sequencer
  import stim_seq_pkg::*;
#(
  parameter int unsigned PAYLOAD_W     = 32,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned RESET_TIMEOUT = DEF_RESET_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_do_reset,
  input  logic [PAYLOAD_W-1:0] cmd_payload,
  output logic                 stimuli_valid,
  output logic                 do_reset,
  output logic [PAYLOAD_W-1:0] stimuli_data,
  input  logic                 dut_resetn,
  output logic                 active,
  output logic                 err_timeout,
  output logic [15:0]          reset_count
);

  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(RESET_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LD_SETTLE  = CNT_W'(SETTLE_CYCLES - 1);

  stim_seq_state_t        r_state;
  stim_seq_state_t        w_next;
  logic                   r_rst_req;
  logic                   r_stimuli_valid;
  logic                   r_do_reset;
  logic                   r_active;
  logic                   r_err_timeout;
  logic [15:0]            r_reset_count;
  logic [PAYLOAD_W-1:0]   r_stimuli_data;
  logic                   w_accept;
  logic                   w_load;
  logic [CNT_W-1:0]       w_load_val;
  logic                   w_dec;
  logic                   w_zero;
  logic                   w_timeout;
  logic                   w_count_inc;
  logic                   w_unrequested;

  assign cmd_ready = !reset && dut_resetn &&
                     ((r_state == ST_IDLE) || (r_state == ST_ACTIVE));
  assign w_accept  = cmd_valid && cmd_ready;

  sat_down_counter #(
    .W (CNT_W)
  ) u_cnt (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Loading with N-1 on entry makes the state last exactly N cycles.
  always_comb begin
    w_next        = r_state;
    w_load        = 1'b0;
    w_load_val    = '0;
    w_dec         = 1'b0;
    w_timeout     = 1'b0;
    w_unrequested = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_ARM;
      end
      ST_ARM: begin
        w_next = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (r_rst_req) begin
          w_next     = ST_WAIT_LOW;
          w_load     = 1'b1;
          w_load_val = LD_TIMEOUT;
        end else begin
          w_next = ST_ACTIVE;
        end
      end
      ST_WAIT_LOW: begin
        if (!dut_resetn) begin
          w_next     = ST_WAIT_HIGH;
          w_load     = 1'b1;
          w_load_val = LD_TIMEOUT;
        end else if (w_zero) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (dut_resetn) begin
          w_next     = ST_SETTLE;
          w_load     = 1'b1;
          w_load_val = LD_SETTLE;
        end else if (w_zero) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_zero) w_next = ST_ACTIVE;
        else        w_dec  = 1'b1;
      end
      ST_ACTIVE: begin
        if (!dut_resetn) begin
          w_next        = ST_WAIT_HIGH;
          w_load        = 1'b1;
          w_load_val    = LD_TIMEOUT;
          w_unrequested = 1'b1;
        end else if (w_accept) begin
          w_next = ST_ARM;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Only a reset this block requested is counted; r_rst_req is cleared on an unrequested one.
  assign w_count_inc = (r_state == ST_WAIT_HIGH) && dut_resetn && r_rst_req &&
                       (r_reset_count != 16'hFFFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rst_req       <= 1'b0;
      r_stimuli_data  <= '0;
      r_stimuli_valid <= 1'b0;
      r_do_reset      <= 1'b0;
      r_active        <= 1'b0;
      r_err_timeout   <= 1'b0;
      r_reset_count   <= '0;
    end else begin
      if (w_accept) begin
        r_rst_req      <= cmd_do_reset;
        r_stimuli_data <= cmd_payload;
      end else if (w_unrequested) begin
        r_rst_req <= 1'b0;
      end
      r_stimuli_valid <= (w_next == ST_ASSERT)    || (w_next == ST_WAIT_LOW) ||
                         (w_next == ST_WAIT_HIGH) || (w_next == ST_SETTLE)   ||
                         (w_next == ST_ACTIVE);
      r_do_reset      <= ((w_next == ST_ASSERT) && r_rst_req) || (w_next == ST_WAIT_LOW);
      r_active        <= (w_next == ST_ACTIVE);
      if (w_timeout)   r_err_timeout <= 1'b1;
      if (w_count_inc) r_reset_count <= r_reset_count + 16'd1;
    end
  end

  assign stimuli_valid = r_stimuli_valid;
  assign do_reset      = r_do_reset;
  assign stimuli_data  = r_stimuli_data;
  assign active        = r_active;
  assign err_timeout   = r_err_timeout;
  assign reset_count   = r_reset_count;

endmodule
